// File: rtl/iir_sos_cascade_tdm_if.sv
// Sample, coefficient and status signals of the TDM biquad cascade.
// The master drives samples and coefficients; the slave is the filter.
interface iir_sos_cascade_tdm_if #(
   parameter int N_STAGES  = 4,
   parameter int COEF_SIZE = 20,
   parameter int DATA_SIZE = 24
);
   localparam int AW = $clog2(N_STAGES) + 3;

   logic                        sample_trig;
   logic signed [DATA_SIZE-1:0] data_in;
   logic                        coef_wr_en;
   logic [AW-1:0]               coef_wr_addr;
   logic signed [COEF_SIZE-1:0] coef_wr_data;
   logic                        coef_commit;
   logic signed [DATA_SIZE-1:0] data_out;
   logic                        data_valid;
   logic                        busy;
   logic                        overrun;
   logic                        commit_done;

   modport master (
      output sample_trig, data_in,
      output coef_wr_en, coef_wr_addr,
      output coef_wr_data, coef_commit,
      input  data_out, data_valid,
      input  busy, overrun, commit_done
   );

   modport slave (
      input  sample_trig, data_in,
      input  coef_wr_en, coef_wr_addr,
      input  coef_wr_data, coef_commit,
      output data_out, data_valid,
      output busy, overrun, commit_done
   );
endinterface

// File: rtl/iir_sos_cascade_tdm.sv
// Cascade of direct-form-I biquads sharing one multiplier, 7 cycles/stage.
// Double-buffered coefficients: shadow takes writes, commit copies to active.
module iir_sos_cascade_tdm #(
   parameter int N_STAGES  = 4,
   parameter int COEF_SIZE = 20,
   parameter int COEF_FRAC = 18,
   parameter int DATA_SIZE = 24
) (
   input logic clk,
   input logic reset,
   iir_sos_cascade_tdm_if.slave bus
);
   localparam int SW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam int PW    = COEF_SIZE + DATA_SIZE;
   localparam int ACC_W = DATA_SIZE + COEF_SIZE + 3;

   typedef logic signed [COEF_SIZE-1:0] coef_t;
   typedef logic signed [DATA_SIZE-1:0] data_t;
   typedef logic signed [ACC_W:0]       wide_t;

   localparam coef_t ONE  = COEF_SIZE'(1) << COEF_FRAC;
   localparam data_t DMAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam data_t DMIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
   localparam wide_t HALF = (ACC_W+1)'(1) <<< (COEF_FRAC-1);
   localparam wide_t TMAX = (ACC_W+1)'(DMAX);
   localparam wide_t TMIN = (ACC_W+1)'(DMIN);
   localparam logic [SW-1:0] LAST = SW'(N_STAGES-1);

   typedef enum logic [2:0] {
      IDLE, GAIN, MAC_B0, MAC_B1,
      MAC_B2, MAC_A1, MAC_A2, WB
   } state_t;

   state_t  state;
   logic [SW-1:0] stage;
   logic    pending;
   coef_t   shadow [N_STAGES][6];
   coef_t   active [N_STAGES][6];
   data_t   x1 [N_STAGES];
   data_t   x2 [N_STAGES];
   data_t   y1 [N_STAGES];
   data_t   y2 [N_STAGES];
   data_t   xin;
   data_t   xg;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [PW-1:0]    prod;
   coef_t   mc;
   data_t   md;
   data_t   y_wb;
   logic [SW-1:0] ws;
   logic [2:0]    wi;

   // Round half-up at the binary point, then clamp to sample range
   function automatic data_t rnd_sat(input logic signed [ACC_W-1:0] a);
      wide_t t;
      t = a;
      t = (t + HALF) >>> COEF_FRAC;
      if (t > TMAX) return DMAX;
      else if (t < TMIN) return DMIN;
      else return t[DATA_SIZE-1:0];
   endfunction

   assign ws       = SW'(bus.coef_wr_addr >> 3);
   assign wi       = bus.coef_wr_addr[2:0];
   assign prod     = mc * md;
   assign prod_ext = ACC_W'(prod);
   assign y_wb     = rnd_sat(acc);

   // Select the one coefficient/data pair multiplied this cycle
   always_comb begin
      mc = active[stage][0];
      md = xg;
      case (state)
         GAIN:   begin mc = active[stage][5]; md = xin;       end
         MAC_B1: begin mc = active[stage][1]; md = x1[stage]; end
         MAC_B2: begin mc = active[stage][2]; md = x2[stage]; end
         MAC_A1: begin mc = active[stage][3]; md = y1[stage]; end
         MAC_A2: begin mc = active[stage][4]; md = y2[stage]; end
         default: ;
      endcase
   end

   // Shadow bank accepts writes at any time; idx 6 and 7 are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < N_STAGES; s++)
            for (int k = 0; k < 6; k++)
               shadow[s][k] <= (k == 0 || k == 5) ? ONE : '0;
      end else if (bus.coef_wr_en && wi < 3'd6 &&
                   int'(ws) < N_STAGES) begin
         shadow[ws][wi] <= bus.coef_wr_data;
      end
   end

   // Sequencer, MAC datapath, history, active bank and status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         stage           <= '0;
         pending         <= 1'b0;
         xin             <= '0;
         xg              <= '0;
         acc             <= '0;
         bus.data_out    <= '0;
         bus.data_valid  <= 1'b0;
         bus.busy        <= 1'b0;
         bus.overrun     <= 1'b0;
         bus.commit_done <= 1'b0;
         for (int s = 0; s < N_STAGES; s++) begin
            x1[s] <= '0;
            x2[s] <= '0;
            y1[s] <= '0;
            y2[s] <= '0;
            for (int k = 0; k < 6; k++)
               active[s][k] <= (k == 0 || k == 5) ? ONE : '0;
         end
      end else begin
         bus.data_valid  <= 1'b0;
         bus.overrun     <= 1'b0;
         bus.commit_done <= 1'b0;
         if (state != IDLE && bus.sample_trig)
            bus.overrun <= 1'b1;
         if (state != IDLE && bus.coef_commit)
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.coef_commit) begin
                  active          <= shadow;
                  bus.commit_done <= 1'b1;
               end
               if (bus.sample_trig) begin
                  xin      <= bus.data_in;
                  stage    <= '0;
                  state    <= GAIN;
                  bus.busy <= 1'b1;
               end
            end
            GAIN: begin
               xg    <= rnd_sat(prod_ext);
               state <= MAC_B0;
            end
            MAC_B0: begin
               acc   <= prod_ext;
               state <= MAC_B1;
            end
            MAC_B1: begin
               acc   <= acc + prod_ext;
               state <= MAC_B2;
            end
            MAC_B2: begin
               acc   <= acc + prod_ext;
               state <= MAC_A1;
            end
            MAC_A1: begin
               acc   <= acc - prod_ext;
               state <= MAC_A2;
            end
            MAC_A2: begin
               acc   <= acc - prod_ext;
               state <= WB;
            end
            WB: begin
               x2[stage] <= x1[stage];
               x1[stage] <= xg;
               y2[stage] <= y1[stage];
               y1[stage] <= y_wb;
               xin       <= y_wb;
               if (stage == LAST) begin
                  state          <= IDLE;
                  bus.busy       <= 1'b0;
                  bus.data_out   <= y_wb;
                  bus.data_valid <= 1'b1;
                  if (pending || bus.coef_commit) begin
                     active          <= shadow;
                     bus.commit_done <= 1'b1;
                     pending         <= 1'b0;
                  end
               end else begin
                  stage <= stage + 1'b1;
                  state <= GAIN;
               end
            end
         endcase
      end
   end
endmodule
